// File: rtl/catc_stall_scheduler.sv
// catc_stall_scheduler
// Grants one stall requester at a time onto the CATC Delay input, tracks the
// emulated-time debt between the reference and stalled CATCs, and drives
// FastCatchup after a stall until the debt has been repaid.
module catc_stall_scheduler #(
  parameter int Requesters       = 4,
  parameter int MaxStall         = 256,
  parameter int DebtWidth        = 16,
  parameter int CatchupThreshold = 64
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [Requesters-1:0] StallReq,
  output logic [Requesters-1:0] StallGrant,
  input  logic                  RefTick,
  input  logic                  CoreTick,
  output logic                  Delay,
  output logic                  FastCatchup,
  output logic [DebtWidth-1:0]  Debt,
  output logic                  Overrun,
  output logic                  Timeout
);

  localparam int PtrW = (Requesters > 1) ? $clog2(Requesters) : 1;
  localparam int CntW = $clog2(MaxStall + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] STALL   = 2'd1;
  localparam logic [1:0] CATCHUP = 2'd2;

  localparam logic [DebtWidth-1:0] DebtMax   = '1;
  localparam logic [DebtWidth-1:0] Threshold = DebtWidth'(CatchupThreshold);
  localparam logic [CntW-1:0]      CntLimit  = CntW'(MaxStall);
  localparam logic [PtrW-1:0]      PtrReset  = PtrW'(Requesters - 1);

  logic [1:0]            state;
  logic [PtrW-1:0]       ptr;
  logic [Requesters-1:0] rearm;
  logic [CntW-1:0]       stallCnt;

  logic [DebtWidth-1:0]  debtNext;
  logic                  overrunHit;
  logic [Requesters-1:0] eligible;
  logic [PtrW-1:0]       winner;
  logic [PtrW-1:0]       cand;
  logic                  found;
  logic                  reqHeld;
  logic [CntW-1:0]       cntInc;
  logic                  forceRelease;
  logic                  releaseNow;

  // Saturating up/down debt update; both ticks together cancel out.
  always_comb begin
    debtNext   = Debt;
    overrunHit = 1'b0;
    if (RefTick && !CoreTick) begin
      if (Debt == DebtMax) overrunHit = 1'b1;
      else                 debtNext   = Debt + DebtWidth'(1);
    end else if (CoreTick && !RefTick && (Debt != '0)) begin
      debtNext = Debt - DebtWidth'(1);
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    eligible = StallReq & ~rearm;
    winner   = ptr;
    found    = 1'b0;
    cand     = ptr;
    for (int i = 1; i <= Requesters; i++) begin
      cand = PtrW'((int'(ptr) + i) % Requesters);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign reqHeld      = StallReq[ptr];
  assign cntInc       = stallCnt + CntW'(1);
  assign forceRelease = (state == STALL) && reqHeld && (cntInc == CntLimit);
  assign releaseNow   = (state == STALL) && (!reqHeld || forceRelease);

  // Debt register and sticky overrun flag, updated in every state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Debt    <= '0;
      Overrun <= 1'b0;
    end else begin
      Debt <= debtNext;
      if (overrunHit) Overrun <= 1'b1;
    end
  end

  // Arbitration state machine with registered grant, Delay, FastCatchup and Timeout.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      ptr         <= PtrReset;
      rearm       <= '0;
      stallCnt    <= '0;
      StallGrant  <= '0;
      Delay       <= 1'b0;
      FastCatchup <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      Timeout <= forceRelease;
      rearm   <= (rearm & StallReq) |
                 (forceRelease ? (Requesters'(1) << ptr) : '0);
      case (state)
        IDLE: begin
          if (found) begin
            state      <= STALL;
            StallGrant <= Requesters'(1) << winner;
            Delay      <= 1'b1;
            ptr        <= winner;
            stallCnt   <= '0;
          end
        end
        STALL: begin
          if (releaseNow) begin
            StallGrant <= '0;
            Delay      <= 1'b0;
            if (debtNext >= Threshold) begin
              state       <= CATCHUP;
              FastCatchup <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            stallCnt <= cntInc;
          end
        end
        CATCHUP: begin
          if (debtNext == '0) begin
            state       <= IDLE;
            FastCatchup <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          StallGrant  <= '0;
          Delay       <= 1'b0;
          FastCatchup <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_catc_stall_scheduler.sv
// Testbench for catc_stall_scheduler: two instances (default sizing and a
// small 4-bit-debt / short-MaxStall variant) share one stimulus stream and
// are compared against a behavioural model through per-instance queues.
module tb_catc_stall_scheduler;

  localparam int MIdle  = 0;
  localparam int MStall = 1;
  localparam int MCatch = 2;

  typedef struct {
    int         mode;
    logic [1:0] owner;
    logic [1:0] lastWin;
    int         held;
    logic [3:0] rearm;
    int         debt;
    bit         overrun;
    bit         timeout;
  } Model;

  typedef struct packed {
    logic [3:0]  grant;
    logic        delay;
    logic        fast;
    logic        timeout;
    logic        overrun;
    logic [15:0] debt;
  } Exp_t;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic [3:0] stallReq = '0;
  logic refTick = 1'b0;
  logic coreTick = 1'b0;

  logic [3:0]  grantA, grantB;
  logic        delayA, delayB, fastA, fastB;
  logic        overrunA, overrunB, timeoutA, timeoutB;
  logic [15:0] debtA;
  logic [3:0]  debtB;

  int tests = 0;
  int fails = 0;

  Model mA, mB;
  Exp_t expA[$];
  Exp_t expB[$];

  int runA = 0;
  int maxRunA = 0;
  int timeoutCntA = 0;

  catc_stall_scheduler #(
    .Requesters(4), .MaxStall(256), .DebtWidth(16), .CatchupThreshold(64)
  ) dutA (
    .Clk(clk), .Reset_n(resetN), .StallReq(stallReq), .StallGrant(grantA),
    .RefTick(refTick), .CoreTick(coreTick), .Delay(delayA),
    .FastCatchup(fastA), .Debt(debtA), .Overrun(overrunA), .Timeout(timeoutA)
  );

  catc_stall_scheduler #(
    .Requesters(4), .MaxStall(16), .DebtWidth(4), .CatchupThreshold(4)
  ) dutB (
    .Clk(clk), .Reset_n(resetN), .StallReq(stallReq), .StallGrant(grantB),
    .RefTick(refTick), .CoreTick(coreTick), .Delay(delayB),
    .FastCatchup(fastB), .Debt(debtB), .Overrun(overrunB), .Timeout(timeoutB)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  function automatic void modelReset(inout Model m);
    m.mode    = MIdle;
    m.owner   = 2'd0;
    m.lastWin = 2'd3;
    m.held    = 0;
    m.rearm   = '0;
    m.debt    = 0;
    m.overrun = 0;
    m.timeout = 0;
  endfunction

  // One clock edge of the scheduler described in plain arithmetic.
  function automatic void modelStep(inout Model m, input logic [3:0] req,
                                    input logic r, input logic c,
                                    input int maxStall, input int debtMax,
                                    input int thr);
    int nd;
    bit rel;
    logic [1:0] cand;
    nd = m.debt + (r ? 1 : 0) - (c ? 1 : 0);
    if (nd > debtMax) begin
      nd = debtMax;
      m.overrun = 1;
    end
    if (nd < 0) nd = 0;
    m.timeout = 0;
    rel = 0;
    if (m.mode == MIdle) begin
      for (int i = 1; i <= 4; i++) begin
        cand = m.lastWin + 2'(i);
        if (m.mode == MIdle && req[cand] && !m.rearm[cand]) begin
          m.mode    = MStall;
          m.owner   = cand;
          m.lastWin = cand;
          m.held    = 1;
        end
      end
    end else if (m.mode == MStall) begin
      if (!req[m.owner]) rel = 1;
      else if (m.held == maxStall) begin
        rel = 1;
        m.timeout = 1;
        m.rearm[m.owner] = 1'b1;
      end else m.held++;
      if (rel) m.mode = (nd >= thr) ? MCatch : MIdle;
    end else if (nd == 0) begin
      m.mode = MIdle;
    end
    for (int i = 0; i < 4; i++)
      if (!req[i]) m.rearm[i] = 1'b0;
    m.debt = nd;
  endfunction

  function automatic Exp_t toExp(input Model m);
    Exp_t e;
    e.grant   = (m.mode == MStall) ? (4'b0001 << m.owner) : 4'b0000;
    e.delay   = (m.mode == MStall);
    e.fast    = (m.mode == MCatch);
    e.timeout = m.timeout;
    e.overrun = m.overrun;
    e.debt    = 16'(m.debt);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, queue expectations.
  task automatic applyStimulus(input logic [3:0] req, input logic r, input logic c);
    stallReq = req;
    refTick  = r;
    coreTick = c;
    @(posedge clk);
    if (!resetN) begin
      modelReset(mA);
      modelReset(mB);
    end else begin
      modelStep(mA, req, r, c, 256, 65535, 64);
      modelStep(mB, req, r, c, 16, 15, 4);
    end
    expA.push_back(toExp(mA));
    expB.push_back(toExp(mB));
    #1;
  endtask

  // Monitor: pop expectations and compare against both DUTs after each edge.
  initial begin
    Exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expA.size() > 0) begin
        e = expA.pop_front();
        checkOutput("A grant",   32'(grantA),   32'(e.grant));
        checkOutput("A delay",   32'(delayA),   32'(e.delay));
        checkOutput("A fast",    32'(fastA),    32'(e.fast));
        checkOutput("A timeout", 32'(timeoutA), 32'(e.timeout));
        checkOutput("A overrun", 32'(overrunA), 32'(e.overrun));
        checkOutput("A debt",    32'(debtA),    32'(e.debt));
      end
      if (expB.size() > 0) begin
        e = expB.pop_front();
        checkOutput("B grant",   32'(grantB),   32'(e.grant));
        checkOutput("B delay",   32'(delayB),   32'(e.delay));
        checkOutput("B fast",    32'(fastB),    32'(e.fast));
        checkOutput("B timeout", 32'(timeoutB), 32'(e.timeout));
        checkOutput("B overrun", 32'(overrunB), 32'(e.overrun));
        checkOutput("B debt",    32'(debtB),    32'(e.debt));
      end
      if (delayA) begin
        runA++;
        if (runA > maxRunA) maxRunA = runA;
      end else runA = 0;
      if (timeoutA) timeoutCntA++;
    end
  end

  // Main stimulus sequence.
  initial begin
    logic [3:0] dropped;
    logic [3:0] req;
    logic r, c;
    modelReset(mA);
    modelReset(mB);
    #1 resetN = 1'b0;
    repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);
    resetN = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0);

    // Short stall from requester 0 with sparse reference ticks.
    for (int i = 0; i < 10; i++) applyStimulus(4'b0001, (i % 4) == 0, 1'b0);
    #2 checkOutput("T1 debt", 32'(debtA), 32'd3);
    repeat (4) applyStimulus(4'b0000, 1'b0, 1'b0);

    // All four request; each drops after five granted cycles.
    dropped = '0;
    for (int i = 0; i < 40; i++) begin
      if (mA.mode == MStall && mA.held == 5) dropped |= (4'b0001 << mA.owner);
      applyStimulus(4'b1111 & ~dropped, 1'b0, 1'b0);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0);

    // Requester 1 holds for 300 cycles and is forced off at MaxStall.
    #2;
    maxRunA = 0;
    timeoutCntA = 0;
    repeat (300) applyStimulus(4'b0010, 1'b0, 1'b0);
    #2;
    checkOutput("T3 delay run", 32'(maxRunA), 32'd256);
    checkOutput("T3 timeouts", 32'(timeoutCntA), 32'd1);
    repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0);
    repeat (6) applyStimulus(4'b0010, 1'b0, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0);

    // Drain, then an 80-cycle stall accumulating debt, then catch-up.
    repeat (20) applyStimulus(4'b0000, 1'b0, 1'b1);
    repeat (80) applyStimulus(4'b0100, 1'b1, 1'b0);
    #2;
    checkOutput("T4 debt", 32'(debtA), 32'd80);
    checkOutput("T4 B debt saturated", 32'(debtB), 32'd15);
    checkOutput("T4 B overrun", 32'(overrunB), 32'd1);
    repeat (100) applyStimulus(4'b0001, 1'b0, 1'b1);
    #2;
    checkOutput("T5 B debt floor", 32'(debtB), 32'd0);
    checkOutput("T5 B overrun sticky", 32'(overrunB), 32'd1);
    repeat (3) applyStimulus(4'b0000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a stall.
    repeat (5) applyStimulus(4'b0100, 1'b1, 1'b0);
    #2 resetN = 1'b0;
    #1;
    checkOutput("T6 A outputs in reset",
                32'({grantA, delayA, fastA, overrunA, timeoutA, debtA}), 32'd0);
    checkOutput("T6 B outputs in reset",
                32'({grantB, delayB, fastB, overrunB, timeoutB, debtB}), 32'd0);
    modelReset(mA);
    modelReset(mB);
    repeat (2) applyStimulus(4'b0100, 1'b0, 1'b0);
    resetN = 1'b1;
    repeat (6) applyStimulus(4'b1111, 1'b0, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0, 1'b0);

    // Randomized traffic: debt drifts up in the first half, down in the second.
    req = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      if (i < 1500) begin
        r = ($urandom_range(3) != 0);
        c = ($urandom_range(1) == 0);
      end else begin
        r = ($urandom_range(1) == 0);
        c = ($urandom_range(3) != 0);
      end
      applyStimulus(req, r, c);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0);
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/catc_stall_scheduler.md
# catc_stall_scheduler

Arbitrates emulated-time stall requests from several subsystems (memory, DMA, video fetch) onto the single `Delay` input of a `RetroCATC` instance. It tracks the emulated-time debt: reference ticks from an unstalled `RetroCATC` minus ticks from the stalled one. Once stalls end, it drives `FastCatchup` until the debt is repaid. It sits between the requesting subsystems and the CATC pair in the core clock domain.

## Interface
- `Requesters`, 4: number of stall requesters (2..8).
- `MaxStall`, 256: maximum consecutive cycles `Delay` may be held for one grant (≥2).
- `DebtWidth`, 16: width of the debt counter.
- `CatchupThreshold`, 64: debt at or above which a released stall enters catch-up (1..2^DebtWidth−1).
- `Clk`  in  1  core clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `StallReq`  in  Requesters  per-requester level request to freeze emulated time.
- `StallGrant`  out  Requesters  one-hot grant; registered.
- `RefTick`  in  1  `ClkEnOut` of the unstalled reference CATC.
- `CoreTick`  in  1  `ClkEnOut` of the stalled CATC.
- `Delay`  out  1  to CATC `Delay`; registered.
- `FastCatchup`  out  1  to CATC `FastCatchup`; registered.
- `Debt`  out  DebtWidth  current emulated-time debt in ticks.
- `Overrun`  out  1  sticky; set when the debt saturates.
- `Timeout`  out  1  one-cycle pulse on a forced release at `MaxStall`.

## Operation
- States: `IDLE`, `STALL`, `CATCHUP`. Reset → `IDLE`.
- `IDLE`:
  - `Delay`=0, `FastCatchup`=0, no grant.
  - If any eligible `StallReq` is high: grant the round-robin winner, go to `STALL`, `Delay`=1, and clear the stall counter.
- Round-robin:
  - The search starts at the last granted index + 1, modulo `Requesters`.
  - The pointer resets to `Requesters`−1, so requester 0 wins first.
  - The pointer updates on every grant.
- Eligibility: a requester is eligible unless its rearm bit is set.
  - The rearm bit is set on a forced release.
  - It clears on the first cycle that requester's `StallReq` is sampled low.
- `STALL`:
  - `Delay`=1 and the grant is held; the stall counter increments each cycle.
  - Release when the granted `StallReq` is sampled low, or when the counter reaches `MaxStall` (forced release).
  - On a forced release, pulse `Timeout` and set the requester's rearm bit.
  - On release: go to `CATCHUP` if next-`Debt` ≥ `CatchupThreshold`, else to `IDLE`. Drop the grant and `Delay` on the same edge.
  - If the request drops on the same cycle the counter reaches `MaxStall`, it is a normal release: no `Timeout`, no rearm bit.
  - Other requesters' `StallReq` are ignored while in `STALL`.
- `CATCHUP`:
  - `FastCatchup`=1, `Delay`=0, no grants.
  - Go to `IDLE` when next-`Debt` = 0; `FastCatchup` falls on that edge.
- Debt arithmetic, evaluated every cycle in every state:
  - `Debt` ← `Debt` + `RefTick` − `CoreTick`.
  - Both ticks high leaves `Debt` unchanged.
  - `Debt` saturates at 2^DebtWidth−1; an increment attempted at saturation sets `Overrun`.
  - `Debt` floors at 0; a `CoreTick` with no `RefTick` at `Debt`=0 holds 0.
  - `Overrun` clears only on reset.
- Reset mid-operation (`Reset_n` low at any time) asynchronously forces:
  - all outputs 0 and state `IDLE`;
  - `Debt`=0, pointer = `Requesters`−1, rearm bits 0, stall counter 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `StallReq` sampled high at edge k in `IDLE` → `StallGrant` and `Delay` high after edge k.
- Release: granted `StallReq` sampled low at edge k → `StallGrant` and `Delay` low after edge k.
- `Delay` is high for at most `MaxStall` consecutive cycles. The forced release happens at the edge where the counter equals `MaxStall`.
- `Debt` updates one cycle after the tick inputs are sampled. State decisions use next-`Debt`.
- Minimum gap between two grants is one `IDLE` cycle.
- `Timeout` is high for exactly one cycle, coincident with the first cycle `Delay` is low.

## Test plan
- Reset, then `StallReq`=4'b0001 for 10 cycles with `RefTick` pulsing every 4 cycles and `CoreTick`=0 → grant 4'b0001 one cycle later; `Delay` high 10 cycles; `Debt` reaches 2 or 3; return to `IDLE` (below threshold); `FastCatchup` never high.
- `StallReq`=4'b1111 held, each requester dropping its request after 5 granted cycles → grants in order 0,1,2,3 with one `IDLE` cycle between them; `Delay` never high for more than 5 consecutive cycles.
- `StallReq`=4'b0010 held for 300 cycles with `MaxStall`=256 → `Delay` high exactly 256 cycles; `Timeout` pulses once; requester 1 is not regranted until its `StallReq` has been sampled low for one cycle.
- `RefTick` held at 1 and `CoreTick` at 0 during an 80-cycle stall → `Debt`=80, enter `CATCHUP`. Then `CoreTick`=1, `RefTick`=0 → `Debt` counts down; `FastCatchup` falls the edge `Debt` hits 0; a request pending during catch-up is granted only after that.
- `DebtWidth`=4, `RefTick`=1 for 20 cycles while stalled → `Debt` saturates at 15 and `Overrun` is set. `CoreTick` without `RefTick` at `Debt`=0 → `Debt` stays 0.
- Pull `Reset_n` low mid-`STALL`, then release it → all outputs 0 immediately; `Debt` and `Overrun` clear; the first grant after reset goes to requester 0.
